// File: rtl/axis_arb_pkg.sv
// Shared types and constants for the 4:1 AXI-Stream round-robin arbiter.
package axis_arb_pkg;

  localparam int N_REQ = 4;

  typedef logic [1:0] sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: first set bit of eff_req
// scanning ptr, ptr+1, ... with wrap-around.
module rr_pick4
  import axis_arb_pkg::*;
(
  input  logic [N_REQ-1:0] eff_req,
  input  sel_t             ptr,
  output sel_t             winner,
  output logic             any
);

  sel_t w_idx;

  // Scan from the farthest slot back toward ptr so the nearest hit wins.
  always_comb begin
    winner = ptr;
    w_idx  = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = ptr + sel_t'(k);
      if (eff_req[w_idx]) winner = w_idx;
    end
  end

  assign any = |eff_req;

endmodule

// File: rtl/axis_rr_arb_4to1.sv
// Packet-aware round-robin arbiter driving the sel of a 4:1 AXI-Stream mux.
// Locks sel from first beat to last beat (or MAX_BEATS), then rotates.
module axis_rr_arb_4to1
  import axis_arb_pkg::*;
#(
  parameter int MAX_BEATS = 256,
  parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic             out_valid,
  input  logic             out_ready,
  input  logic             out_last,
  output sel_t             sel,
  output logic             gate,
  output logic             busy,
  output logic             timeout,
  output logic [CNT_W-1:0] beat_cnt
);

  arb_state_t       r_state;
  sel_t             r_ptr;
  sel_t             r_sel;
  logic             r_gate;
  logic             r_timeout;
  logic [CNT_W-1:0] r_cnt;

  logic [N_REQ-1:0] w_eff;
  sel_t             w_win;
  logic             w_any;
  logic             w_acc;
  logic             w_cap;
  logic             w_done;

  assign w_eff  = req & mask;
  // Acceptance only counts while the grant is active; stray valids are ignored.
  assign w_acc  = r_gate & out_valid & out_ready;
  assign w_cap  = (r_cnt == CNT_W'(MAX_BEATS - 1));
  assign w_done = w_acc & (out_last | w_cap);

  rr_pick4 u_pick (
    .eff_req (w_eff),
    .ptr     (r_ptr),
    .winner  (w_win),
    .any     (w_any)
  );

  // Grant/lock state machine, priority pointer and beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_sel     <= '0;
      r_gate    <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_sel   <= w_win;
            r_gate  <= 1'b1;
            r_state <= LOCK;
            r_cnt   <= '0;
          end
        end
        LOCK: begin
          if (w_done) begin
            r_gate    <= 1'b0;
            r_state   <= IDLE;
            r_ptr     <= r_sel + sel_t'(1);
            r_cnt     <= '0;
            r_timeout <= ~out_last;
          end else if (w_acc) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sel      = r_sel;
  assign gate     = r_gate;
  assign busy     = r_gate;
  assign timeout  = r_timeout;
  assign beat_cnt = r_cnt;

endmodule

// File: tb/tb_axis_rr_arb_4to1.sv
// Self-checking bench: directed literal checks plus randomized traffic
// compared every cycle against a packet-level behavioural model.
module tb_axis_rr_arb_4to1;

  localparam int MB = 4;
  localparam int CW = $clog2(MB + 1);

  logic          clk, rst_n;
  logic [3:0]    req, mask;
  logic          out_valid, out_ready, out_last;
  logic [1:0]    sel;
  logic          gate, busy, timeout;
  logic [CW-1:0] beat_cnt;

  int n_vec = 0;
  int n_err = 0;

  axis_rr_arb_4to1 #(.MAX_BEATS(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .mask(mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .sel(sel), .gate(gate), .busy(busy), .timeout(timeout), .beat_cnt(beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: who owns the stream, how many beats it has sent,
  // and whose turn is next.
  bit       m_busy;
  int       m_owner, m_next, m_beats;
  bit       m_to;
  bit [3:0] m_eff;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_owner = 0; m_next = 0; m_beats = 0; m_to = 0; m_eff = '0;
    end else begin
      m_to  = 0;
      m_eff = req & mask;
      if (!m_busy) begin
        for (int k = 0; k < 4; k++) begin
          if (!m_busy && m_eff[(m_next + k) % 4]) begin
            m_owner = (m_next + k) % 4;
            m_busy  = 1;
            m_beats = 0;
          end
        end
      end else if (out_valid && out_ready) begin
        m_beats++;
        if (out_last || m_beats == MB) begin
          m_to    = !out_last;
          m_busy  = 0;
          m_next  = (m_owner + 1) % 4;
          m_beats = 0;
        end
      end
    end
  end

  // Per-cycle comparison plus fairness tracking on the DUT's own grants.
  int wait_pk [4];
  bit prev_gate;
  initial begin
    prev_gate = 0;
    for (int i = 0; i < 4; i++) wait_pk[i] = 0;
  end

  always @(negedge clk) begin
    chk("sel",      int'(sel),      m_owner);
    chk("gate",     int'(gate),     int'(m_busy));
    chk("busy",     int'(busy),     int'(m_busy));
    chk("timeout",  int'(timeout),  int'(m_to));
    chk("beat_cnt", int'(beat_cnt), m_beats);
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) wait_pk[i] = 0;
    end else begin
      for (int i = 0; i < 4; i++) if (!m_eff[i]) wait_pk[i] = 0;
      if (gate && !prev_gate) begin
        for (int i = 0; i < 4; i++) begin
          if (i == int'(sel)) wait_pk[i] = 0;
          else if (m_eff[i]) begin
            wait_pk[i]++;
            chk("fair_wait_le3", int'(wait_pk[i] <= 3), 1);
          end
        end
      end
    end
    prev_gate = gate;
  end

  task automatic beats(input int n, input bit lst);
    for (int b = 1; b <= n; b++) begin
      out_valid = 1; out_ready = 1; out_last = lst && (b == n);
      @(negedge clk);
    end
    out_valid = 0; out_ready = 0; out_last = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  int exp_seq [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n = 0; req = '0; mask = 4'hF; out_valid = 0; out_ready = 0; out_last = 0;
    repeat (3) @(negedge clk);
    chk("rst_sel", int'(sel), 0);
    chk("rst_gate", int'(gate), 0);
    chk("rst_cnt", int'(beat_cnt), 0);

    // Two requesters alternate with 3-beat packets and one bubble between.
    rst_n = 1; req = 4'b0101;
    @(negedge clk);
    chk("t1_sel0", int'(sel), 0); chk("t1_gate", int'(gate), 1);
    beats(3, 1);
    chk("t1_rel", int'(gate), 0); chk("t1_cnt0", int'(beat_cnt), 0);
    @(negedge clk);
    chk("t1_sel2", int'(sel), 2); chk("t1_gate2", int'(gate), 1);
    beats(3, 1);
    chk("t1_rel2", int'(gate), 0);
    @(negedge clk);
    chk("t1_sel0b", int'(sel), 0);
    beats(3, 1);
    req = '0;

    // All requesting, single-beat packets: 0,1,2,3,0.
    do_reset();
    req = 4'hF;
    foreach (exp_seq[j]) begin
      @(negedge clk);
      chk("t2_sel", int'(sel), exp_seq[j]); chk("t2_gate1", int'(gate), 1);
      beats(1, 1);
      chk("t2_gate0", int'(gate), 0);
    end
    req = '0;  // ptr now 1

    // Forced release after MAX_BEATS without last.
    @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    chk("t3_sel", int'(sel), 2);
    beats(3, 0);
    chk("t3_cnt3", int'(beat_cnt), 3); chk("t3_noto", int'(timeout), 0);
    out_valid = 1; out_ready = 1; out_last = 0; req = '0;
    @(negedge clk);
    out_valid = 0; out_ready = 0;
    chk("t3_to", int'(timeout), 1); chk("t3_gate", int'(gate), 0);
    chk("t3_cnt0", int'(beat_cnt), 0);
    @(negedge clk);
    chk("t3_to_pulse", int'(timeout), 0);

    // Downstream stall holds sel and beat count (ptr=3, winner wraps to 0).
    req = 4'b0001;
    @(negedge clk);
    chk("t4_sel", int'(sel), 0);
    beats(1, 0);
    for (int c = 0; c < 5; c++) begin
      out_valid = 1; out_ready = 0;
      @(negedge clk);
      chk("t4_hold_sel", int'(sel), 0); chk("t4_hold_cnt", int'(beat_cnt), 1);
      chk("t4_hold_gate", int'(gate), 1);
    end
    beats(1, 1);
    req = '0;  // ptr now 1

    // Masked requester is never granted; mask changes during a lock are ignored.
    mask = 4'b1101; req = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t5_masked", int'(gate), 0);
    end
    req = 4'b0011;
    @(negedge clk);
    chk("t5_sel0", int'(sel), 0);
    mask = 4'hF; req = 4'b0010;
    repeat (2) @(negedge clk);
    chk("t5_lock_sel", int'(sel), 0);
    mask = 4'b1101;
    beats(2, 1);
    chk("t5_rel", int'(gate), 0);
    mask = 4'hF; req = '0;
    out_valid = 1; out_ready = 1;
    repeat (2) @(negedge clk);
    chk("t5_stray_cnt", int'(beat_cnt), 0); chk("t5_stray_gate", int'(gate), 0);
    out_valid = 0; out_ready = 0;

    // Async reset mid-packet, then re-arbitrate from ptr=0 (ptr was 1).
    req = 4'b1000;
    @(negedge clk);
    chk("t6_sel3", int'(sel), 3);
    beats(2, 0);
    chk("t6_cnt2", int'(beat_cnt), 2);
    #2 rst_n = 0;
    #1;
    chk("t6_async_gate", int'(gate), 0); chk("t6_async_sel", int'(sel), 0);
    chk("t6_async_cnt", int'(beat_cnt), 0);
    @(negedge clk);
    rst_n = 1; req = 4'hF;
    @(negedge clk);
    chk("t6_regrant", int'(sel), 0); chk("t6_regate", int'(gate), 1);
    beats(1, 1);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(7) == 0) req[i] = ~req[i];
      if ($urandom_range(31) == 0) mask = 4'($urandom);
      if ($urandom_range(15) == 0) mask = 4'hF;
      out_valid = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      out_last  = ($urandom_range(2) == 0);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axis_rr_arb_4to1.md
Name: axis_rr_arb_4to1

Overview:
- Packet-aware round-robin arbiter that drives the `sel` input of the 4:1 AXI-Stream mux.
- Watches the four upstream `valid` lines and the muxed output handshake.
- Holds `sel` stable from the first beat through the `last` beat of a packet, then rotates priority.
- Sits beside the mux in every stream-merge point; it does not touch data.

Parameters:
- MAX_BEATS, 256, forced release after this many accepted beats if `last` never arrives (minimum 1).
- CNT_W, $clog2(MAX_BEATS+1), width of the beat counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  4  `valid_0..valid_3` of the mux inputs; bit i = requester i.
- mask  in  4  per-requester enable; 0 = never grant this requester (sampled each cycle).
- out_valid  in  1  mux output `valid`.
- out_ready  in  1  downstream `ready` at the mux output.
- out_last  in  1  `last` flag of the selected stream, muxed alongside data.
- sel  out  2  drives the mux `sel`.
- gate  out  1  1 = grant active; integration ANDs it into the mux output `valid` and `ready`.
- busy  out  1  same as `gate`; kept for status and registers.
- timeout  out  1  1-cycle pulse when a packet is released by MAX_BEATS.
- beat_cnt  out  CNT_W  beats accepted in the current packet.

Behaviour:
- Reset values (async, while rst_n=0):
  - sel=0, gate=0, busy=0, timeout=0, beat_cnt=0.
  - Priority pointer ptr=0; state=IDLE.
  - Reset mid-packet abandons the grant immediately; no drain.
- Definitions:
  - eff_req = req & mask.
  - acc = gate & out_valid & out_ready.
- State IDLE:
  - If eff_req≠0, pick winner = first set bit scanning ptr, ptr+1, …, wrapping mod 4.
  - On the same edge: sel←winner, gate←1, state→LOCK, beat_cnt←0.
  - If eff_req=0, nothing changes; sel keeps its last value.
- State LOCK:
  - sel frozen; `req` and `mask` changes are ignored, including deassertion of the granted request.
  - On acc: beat_cnt←beat_cnt+1.
  - On acc & (out_last | beat_cnt==MAX_BEATS-1):
    - gate←0, state→IDLE, ptr←sel+1 (mod 4), beat_cnt←0.
    - timeout←1 only when out_last=0.
- Latency and throughput:
  - Grant is visible one cycle after eff_req rises.
  - Exactly one idle bubble cycle between consecutive packets (release cycle → IDLE → re-grant edge).
  - Back-to-back single-beat packets sustain 1 beat per 2 cycles.
- Fairness: no requester waits more than 3 packets while continuously requesting and unmasked.
- Boundary conditions:
  - Single-beat packet (out_last on the first acc) releases on that beat; beat_cnt returns to 0.
  - MAX_BEATS=1 releases on every beat.
  - out_valid while gate=0 is not an acceptance and is ignored.
  - Simultaneous release and a new request: the new request is evaluated in the following IDLE cycle with the updated ptr.
  - ptr wraps 3→0.
- Sequencing: purely synchronous apart from rst_n; no combinational path from `req` to `sel`.

Decomposition:
- Package `axis_arb_pkg`:
  - typedef `arb_state_t` enum {IDLE, LOCK}.
  - constant `N_REQ=4`.
  - typedef `sel_t` logic[1:0].
- One sub-module `rr_pick4`: combinational priority rotate; inputs eff_req and ptr; outputs winner and any.
- All registers, the state machine and the beat counter live in the top module.

Test Plan:
- Reset then req=4'b0101, mask=4'hF, 3-beat packets: sel=0 granted at cycle 1; release on beat 3 last; then sel=2; then sel=0 again (alternation, one bubble between packets).
- req=4'b1111 continuous, single-beat packets: sel sequence 0,1,2,3,0; gate toggles 1,0 per packet.
- MAX_BEATS=4, packet with no out_last: release after the 4th acc; timeout pulses exactly once; beat_cnt returns to 0.
- Downstream stalls: out_ready=0 for 5 cycles mid-packet → sel and beat_cnt hold; the grant is not released.
- mask=4'b1101 with req=4'b0010: never granted, gate stays 0. Clearing bit1 of mask mid-packet of another requester does not change sel.
- rst_n pulsed low mid-packet (beat 2): all outputs 0 asynchronously. After release, the arbiter re-arbitrates from ptr=0.
